// File: rtl/pipe_share_arbiter_pkg.sv
// Shared types and constants for pipe_share_arbiter: index sizing helper, tag payload, defaults.
package pipe_share_arbiter_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_LATENCY = 3;
    localparam int unsigned DEF_MAX_OUT = 2;
    localparam int unsigned MAX_NUM_REQ = 8;

    // Ceiling log2, never below 1 so single-bit selects stay legal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam int unsigned IDX_W = clog2_min1(MAX_NUM_REQ);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/pipe_share_arbiter_rr_arbiter.sv
// Combinational round-robin grant with a registered search pointer that advances past each winner.
module rr_arbiter
    import pipe_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned PTR_W  = clog2_min1(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] eligible,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [PTR_W-1:0]   grant_idx_c
);

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;
    logic [PTR_W:0]   cand;
    logic             found;

    // Scan upward from rr_ptr, wrapping, and take the first eligible requester.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && eligible[cand[PTR_W-1:0]]) begin
                found       = 1'b1;
                grant_idx_c = cand[PTR_W-1:0];
            end
        end
        if (found) begin
            grant_c[grant_idx_c] = 1'b1;
        end

        rr_ptr_d = rr_ptr_q;
        if (advance && found) begin
            rr_ptr_d = (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Shares one fixed-latency pipeline among NUM_REQ requesters and routes results back by tag.
// Optional per-requester grant counters on perf_grants when PIPE_SHARE_ARB_PERF_EN is defined.
module pipe_share_arbiter
    import pipe_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned MAX_OUT = DEF_MAX_OUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      pipe_in_valid,
    output logic [DATA_W-1:0]         pipe_x,
    input  logic [DATA_W-1:0]         pipe_out,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
`ifdef PIPE_SHARE_ARB_PERF_EN
    output logic [NUM_REQ*32-1:0]     perf_grants,
`endif
    output logic                      idle
);

    localparam int unsigned PTR_W = clog2_min1(NUM_REQ);
    localparam int unsigned CNT_W = clog2_min1(MAX_OUT + 1);

    logic [NUM_REQ-1:0] eligible_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [PTR_W-1:0]   grant_idx_c;
    logic               issue_c;
    logic [NUM_REQ-1:0] resp_hit_c;
    logic               any_tag_c;

    logic [CNT_W-1:0] out_cnt_q [NUM_REQ];
    logic [CNT_W-1:0] out_cnt_d [NUM_REQ];
    tag_t             tag_q     [LATENCY];
    tag_t             tag_d     [LATENCY];

    // Reset also masks eligibility so nothing is accepted during the reset cycle.
    always_comb begin
        eligible_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible_c[i] = req_valid[i] & (out_cnt_q[i] < CNT_W'(MAX_OUT)) & enable & ~rst;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .eligible    (eligible_c),
        .advance     (issue_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    always_comb begin
        issue_c = |grant_c;
        pipe_x  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                pipe_x = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Tag shift register mirrors the datapath latency; the last stage names the result's owner.
    always_comb begin
        tag_d[0].valid = issue_c;
        tag_d[0].idx   = IDX_W'(grant_idx_c);
        for (int unsigned k = 1; k < LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    always_comb begin
        resp_hit_c = '0;
        any_tag_c  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            resp_hit_c[i] = ~rst & tag_q[LATENCY-1].valid & (tag_q[LATENCY-1].idx == IDX_W'(i));
        end
        for (int unsigned k = 0; k < LATENCY; k++) begin
            any_tag_c = any_tag_c | tag_q[k].valid;
        end
    end

    // Outstanding counts: issue adds, delivered result subtracts, both together cancel.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            out_cnt_d[i] = out_cnt_q[i];
            if (grant_c[i] && !resp_hit_c[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + CNT_W'(1);
            end else if (!grant_c[i] && resp_hit_c[i]) begin
                out_cnt_d[i] = out_cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            out_cnt_q <= out_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                assert (out_cnt_q[i] <= CNT_W'(MAX_OUT));
                assert (!(resp_hit_c[i] && (out_cnt_q[i] == '0)));
            end
        end
    end

    assign req_ready     = grant_c;
    assign pipe_in_valid = issue_c;
    assign resp_valid    = resp_hit_c;
    assign resp_data     = pipe_out;
    assign idle          = ~any_tag_c & ~issue_c;

`ifdef PIPE_SHARE_ARB_PERF_EN
    logic [31:0] perf_q [NUM_REQ];
    logic [31:0] perf_d [NUM_REQ];

    // Saturating grant counters.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            perf_d[i] = perf_q[i];
            if (grant_c[i] && (perf_q[i] != 32'hFFFF_FFFF)) begin
                perf_d[i] = perf_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                perf_q[i] <= '0;
            end
        end else begin
            perf_q <= perf_d;
        end
    end

    always_comb begin
        perf_grants = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            perf_grants[i*32 +: 32] = perf_q[i];
        end
    end
`endif

endmodule
